fifo_output_control: RTL and testbench

Read-side controller for the team's 16-entry synchronous FIFO. It is the downstream partner of the write-side input control. It takes the write pointer published by the input stage, arbitrates read requests against it, and drives read enable and address to the storage array. It returns read data with a valid strobe and reports empty, almost-empty, occupancy and underflow. Both stages run on the same clk and share the same reset.

---
 rtl/fifo_pkg.sv | 7 +
 rtl/fifo_output_control_if.sv | 27 ++
 rtl/fifo_output_control.sv | 41 ++++
 tb/tb_fifo_output_control.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: widths shared by the FIFO input and output controls so the pointer formats always agree.
package fifo_pkg;
  localparam int FIFO_ADDR_W = 4;
  localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_DATA_W = 8;
endpackage

// File: rtl/fifo_output_control_if.sv
// fifo_output_control_if: read-side bus between the consumer/storage (master) and the output control (slave).
interface fifo_output_control_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
);
  logic              rd_en;
  logic [ADDR_W:0]   wr_ptr;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              empty;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              underflow;
  modport master (
    output rd_en, wr_ptr, mem_rdata,
    input  rd_en_o, rd_addr, rd_data, rd_valid, empty, almost_empty, count, underflow
  );
  modport slave (
    input  rd_en, wr_ptr, mem_rdata,
    output rd_en_o, rd_addr, rd_data, rd_valid, empty, almost_empty, count, underflow
  );
endinterface

// File: rtl/fifo_output_control.sv
// fifo_output_control: read pointer, storage read issue and two-stage read-data return for the 16-entry FIFO.
module fifo_output_control
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AE_THRESH = 2
) (
  input logic clk,
  input logic reset,
  fifo_output_control_if.slave bus
);
  logic [ADDR_W:0] rd_ptr;
  logic            pipe_vld;
  logic            accept;
  // the wrap bit makes the modular difference reach 16 when full
  assign bus.count        = bus.wr_ptr - rd_ptr;
  assign bus.empty        = bus.count == '0;
  assign bus.almost_empty = bus.count <= (ADDR_W+1)'(AE_THRESH);
  assign accept           = bus.rd_en & ~bus.empty;
  always_ff @(posedge clk)
    if (reset) begin
      rd_ptr        <= '0;
      pipe_vld      <= 1'b0;
      bus.rd_en_o   <= 1'b0;
      bus.rd_addr   <= '0;
      bus.rd_data   <= '0;
      bus.rd_valid  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.rd_en_o   <= accept;
      bus.underflow <= accept ? 1'b0 : bus.rd_en | bus.underflow;
      pipe_vld      <= bus.rd_en_o;
      bus.rd_valid  <= pipe_vld;
      if (accept) begin
        rd_ptr      <= rd_ptr + 1'b1;
        bus.rd_addr <= rd_ptr[ADDR_W-1:0];
      end
      if (pipe_vld) bus.rd_data <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_fifo_output_control.sv
// tb_fifo_output_control: table-driven flag/address checks plus a read-data scoreboard against a storage model.
module tb_fifo_output_control;
  import fifo_pkg::*;
  typedef struct {
    logic       r, e;
    logic [4:0] w;
    logic       o;
    logic [3:0] a;
    logic       v, u, em, ae;
    logic [4:0] c;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  logic [7:0] mem [FIFO_DEPTH];
  logic [7:0] sb [$];
  int compared = 0;
  int mismatched = 0;
  fifo_output_control_if bus ();
  fifo_output_control dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.rd_en_o === 1'b1) bus.mem_rdata <= mem[bus.rd_addr];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      compared++;
      if (bus.count > FIFO_DEPTH) begin
        mismatched++;
        $display("FAIL count_range: got %0d expected <= %0d", bus.count, FIFO_DEPTH);
      end
    end
    if (bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL rd_valid_unexpected: got data %0h expected no valid at %0t", bus.rd_data, $time);
      end else chk("rd_data", bus.rd_data, sb.pop_front());
    end
  end
  task automatic step(input logic r, input logic e, input logic [4:0] w);
    reset = r;
    bus.rd_en = e;
    bus.wr_ptr = w;
    @(posedge clk);
    #1;
    if (r) sb.delete();
  endtask
  task automatic apply(input vec_t v, input int i);
    step(v.r, v.e, v.w);
    if (v.o) sb.push_back(mem[v.a]);
    chk($sformatf("rd_en_o[%0d]", i), bus.rd_en_o, v.o);
    chk($sformatf("rd_addr[%0d]", i), bus.rd_addr, v.a);
    chk($sformatf("rd_valid[%0d]", i), bus.rd_valid, v.v);
    chk($sformatf("underflow[%0d]", i), bus.underflow, v.u);
    chk($sformatf("empty[%0d]", i), bus.empty, v.em);
    chk($sformatf("almost_empty[%0d]", i), bus.almost_empty, v.ae);
    chk($sformatf("count[%0d]", i), bus.count, v.c);
  endtask
  task automatic read_run(input int n, input logic [4:0] w, inout int k);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, w);
      chk("wrap_rd_en_o", bus.rd_en_o, 1'b1);
      chk("wrap_rd_addr", bus.rd_addr, k % FIFO_DEPTH);
      sb.push_back(mem[k % FIFO_DEPTH]);
      k++;
    end
    step(1'b0, 1'b0, w);
    chk("wrap_count_end", bus.count, 0);
    chk("wrap_empty_end", bus.empty, 1'b1);
  endtask
  initial begin
    vec_t vecs [22];
    int k;
    for (int i = 0; i < FIFO_DEPTH; i++) mem[i] = 8'hA1 + 8'(i);
    // r e w    o a v u em ae c
    vecs = '{
      '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0},
      '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0},
      '{0, 0, 3, 0, 0, 0, 0, 0, 0, 3},
      '{0, 1, 3, 1, 0, 0, 0, 0, 1, 2},
      '{0, 1, 3, 1, 1, 0, 0, 0, 1, 1},
      '{0, 1, 3, 1, 2, 1, 0, 1, 1, 0},
      '{0, 1, 3, 0, 2, 1, 1, 1, 1, 0},
      '{0, 0, 3, 0, 2, 1, 1, 1, 1, 0},
      '{0, 0, 4, 0, 2, 0, 1, 0, 1, 1},
      '{0, 1, 4, 1, 3, 0, 0, 1, 1, 0},
      '{0, 0, 4, 0, 3, 0, 0, 1, 1, 0},
      '{0, 0, 4, 0, 3, 1, 0, 1, 1, 0},
      '{0, 0, 4, 0, 3, 0, 0, 1, 1, 0},
      '{0, 0, 7, 0, 3, 0, 0, 0, 0, 3},
      '{0, 1, 7, 1, 4, 0, 0, 0, 1, 2},
      '{0, 0, 7, 0, 4, 0, 0, 0, 1, 2},
      '{0, 0, 7, 0, 4, 1, 0, 0, 1, 2},
      '{0, 0, 7, 0, 4, 0, 0, 0, 1, 2},
      '{0, 1, 7, 1, 5, 0, 0, 0, 1, 1},
      '{1, 0, 0, 0, 0, 0, 0, 1, 1, 0},
      '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0},
      '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0}
    };
    bus.mem_rdata = '0;
    for (int i = 0; i < 22; i++) apply(vecs[i], i);
    step(1'b1, 1'b0, 5'd0);
    step(1'b0, 1'b0, 5'd16);
    chk("full_count", bus.count, 16);
    chk("full_empty", bus.empty, 1'b0);
    chk("full_almost_empty", bus.almost_empty, 1'b0);
    k = 0;
    read_run(16, 5'd16, k);
    read_run(4, 5'd20, k);
    read_run(16, 5'd4, k);
    step(1'b0, 1'b0, 5'd4);
    step(1'b0, 1'b0, 5'd4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
